// File: rtl/seu_error_event_logger_if.sv
`default_nettype none
// ============================================================================
// seu_error_event_logger_if : control/status bundle for the SEU event logger
// Revision : 1.0
// ============================================================================
interface seu_error_event_logger_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic               enable;
  logic               clear;
  logic               sampleStrobe;
  logic [47:0]        errCount;
  logic               rdAck;
  logic               dataValid;
  logic [63:0]        dataOut;
  logic [c_LVL_W-1:0] fifoLevel;
  logic               overflow;
  logic [15:0]        dropCount;
  logic               armed;

  modport master (
    output enable, clear, sampleStrobe, errCount, rdAck,
    input  dataValid, dataOut, fifoLevel, overflow, dropCount, armed
  );

  modport slave (
    input  enable, clear, sampleStrobe, errCount, rdAck,
    output dataValid, dataOut, fifoLevel, overflow, dropCount, armed
  );
endinterface
`default_nettype wire

// File: rtl/seu_error_event_logger.sv
`default_nettype none
// ============================================================================
// seu_error_event_logger : timestamps nonzero PRBS7 error-count deltas into a FWFT FIFO
// Revision : 1.0
// ============================================================================
module seu_error_event_logger #(
  parameter int FIFO_DEPTH = 16,
  parameter int TS_WIDTH   = 48
) (
  input  logic                    clock,
  input  logic                    RSTn,
  seu_error_event_logger_if.slave bus
);
  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  logic [1:0]          r_rst_sync;
  logic                w_rst_n;
  state_t              r_state;
  logic                r_armed;
  logic [TS_WIDTH-1:0] r_ts;
  logic [47:0]         r_base;
  logic                r_pend_vld;
  logic [63:0]         r_pend_data;
  logic [63:0]         r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]     r_wr;
  logic [c_AW-1:0]     r_rd;
  logic [c_CW-1:0]     r_cnt;
  logic                r_ovf;
  logic [15:0]         r_drop;

  logic [47:0]         w_diff;
  logic [15:0]         w_delta;
  logic [47:0]         w_ts48;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_wr_en;
  logic                w_drop;

  // Assertion is immediate; release takes two clock edges to propagate.
  always_ff @(posedge clock or negedge RSTn) begin
    if (!RSTn) r_rst_sync <= 2'b00;
    else       r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_diff  = bus.errCount - r_base;
  assign w_delta = (|w_diff[47:16]) ? 16'hFFFF : w_diff[15:0];
  assign w_ts48  = 48'(r_ts);
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == c_CW'(FIFO_DEPTH));
  assign w_pop   = bus.rdAck & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr_en = r_pend_vld & (~w_full | w_pop) & ~bus.clear;
  assign w_drop  = r_pend_vld & w_full & ~w_pop & ~bus.clear;

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= S_IDLE;
      r_armed     <= 1'b0;
      r_ts        <= '0;
      r_base      <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_data <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_drop      <= '0;
    end else if (bus.clear) begin
      r_state    <= S_IDLE;
      r_armed    <= 1'b0;
      r_ts       <= '0;
      r_pend_vld <= 1'b0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_drop     <= '0;
    end else begin
      r_ts       <= r_ts + TS_WIDTH'(1);
      r_pend_vld <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.enable) r_state <= S_ARM;
        end
        S_ARM: begin
          if (!bus.enable) begin
            r_state <= S_IDLE;
          end else if (bus.sampleStrobe) begin
            r_base  <= bus.errCount;
            r_state <= S_RUN;
            r_armed <= 1'b1;
          end
        end
        S_RUN: begin
          if (!bus.enable) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
          end else if (bus.sampleStrobe) begin
            r_base <= bus.errCount;
            if (w_diff != 48'd0) begin
              r_pend_vld  <= 1'b1;
              r_pend_data <= {w_ts48, w_delta};
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_armed <= 1'b0;
        end
      endcase

      if (w_wr_en) r_wr <= r_wr + c_AW'(1);
      if (w_pop)   r_rd <= r_rd + c_AW'(1);

      case ({w_wr_en, w_pop})
        2'b10:   r_cnt <= r_cnt + c_CW'(1);
        2'b01:   r_cnt <= r_cnt - c_CW'(1);
        default: r_cnt <= r_cnt;
      endcase

      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[r_wr] <= r_pend_data;
  end

  assign bus.dataValid = ~w_empty;
  assign bus.dataOut   = w_empty ? 64'd0 : r_mem[r_rd];
  assign bus.fifoLevel = r_cnt;
  assign bus.overflow  = r_ovf;
  assign bus.dropCount = r_drop;
  assign bus.armed     = r_armed;
endmodule
`default_nettype wire

// File: tb/tb_seu_error_event_logger.sv
`default_nettype none
// ============================================================================
// tb_seu_error_event_logger : directed + random stimulus against a queue-based event model
// Revision : 1.0
// ============================================================================
module tb_seu_error_event_logger;
  localparam int DEPTH = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  seu_error_event_logger_if #(.FIFO_DEPTH(DEPTH)) bus ();

  seu_error_event_logger #(
    .FIFO_DEPTH(DEPTH),
    .TS_WIDTH  (48)
  ) dut (
    .clock(clk),
    .RSTn (rstn),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: event queue plus logger mode (0 idle, 1 waiting for baseline, 2 logging)
  logic [63:0] m_q[$];
  logic [47:0] m_ts;
  logic [47:0] m_base;
  int          m_mode;
  bit          m_pend;
  logic [63:0] m_pval;
  bit          m_ovf;
  int          m_drop;
  logic [47:0] cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ts   = '0;
    m_base = '0;
    m_mode = 0;
    m_pend = 0;
    m_pval = '0;
    m_ovf  = 0;
    m_drop = 0;
  endtask

  task automatic model_edge(input bit en, input bit clr, input bit stb,
                            input logic [47:0] c, input bit ack);
    logic [47:0] d;
    if (clr) begin
      m_q.delete();
      m_ts   = '0;
      m_ovf  = 0;
      m_drop = 0;
      m_pend = 0;
      m_mode = 0;
      return;
    end
    if (ack && m_q.size() > 0) void'(m_q.pop_front());
    if (m_pend) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_pval);
      else begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
    end
    m_pend = 0;
    case (m_mode)
      0: if (en) m_mode = 1;
      1: if (!en) m_mode = 0;
         else if (stb) begin m_base = c; m_mode = 2; end
      default: if (!en) m_mode = 0;
         else if (stb) begin
           d      = c - m_base;
           m_base = c;
           if (d != 0) begin
             m_pend = 1;
             m_pval = {m_ts, (d > 48'd65535) ? 16'hFFFF : d[15:0]};
           end
         end
    endcase
    m_ts = m_ts + 48'd1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},    64'(bus.dataValid), 64'(m_q.size() > 0));
    chk({tag, ".level"},    64'(bus.fifoLevel), 64'(m_q.size()));
    chk({tag, ".overflow"}, 64'(bus.overflow),  64'(m_ovf));
    chk({tag, ".drop"},     64'(bus.dropCount), 64'(m_drop));
    chk({tag, ".armed"},    64'(bus.armed),     64'(m_mode == 2));
    if (m_q.size() > 0) chk({tag, ".data"}, bus.dataOut, m_q[0]);
  endtask

  task automatic cyc(input string tag, input bit en, input bit clr, input bit stb,
                     input logic [47:0] c, input bit ack);
    bus.enable       = en;
    bus.clear        = clr;
    bus.sampleStrobe = stb;
    bus.errCount     = c;
    bus.rdAck        = ack;
    @(posedge clk);
    model_edge(en, clr, stb, c, ack);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".valid"},    64'(bus.dataValid), 64'd0);
    chk({tag, ".level"},    64'(bus.fifoLevel), 64'd0);
    chk({tag, ".overflow"}, 64'(bus.overflow),  64'd0);
    chk({tag, ".drop"},     64'(bus.dropCount), 64'd0);
    chk({tag, ".armed"},    64'(bus.armed),     64'd0);
    chk({tag, ".data"},     bus.dataOut,        64'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic random_phase(input int n, input int ack_pct);
    bit en, clr, stb, ack;
    for (int i = 0; i < n; i++) begin
      en  = ($urandom_range(0, 31) != 0);
      clr = ($urandom_range(0, 79) == 0);
      stb = ($urandom_range(0, 2) == 0);
      ack = ($urandom_range(0, 99) < ack_pct);
      case ($urandom_range(0, 3))
        0:       cnt = cnt;
        1:       cnt = cnt + 48'($urandom_range(1, 5));
        2:       cnt = cnt + 48'(60000 + $urandom_range(0, 20000));
        default: cnt = cnt + 48'($urandom_range(1, 300));
      endcase
      cyc("rand", en, clr, stb, cnt, ack);
    end
  endtask

  logic [47:0] t_strobe;

  initial begin
    bus.enable = 0; bus.clear = 0; bus.sampleStrobe = 0; bus.errCount = '0; bus.rdAck = 0;
    cnt = '0;
    model_reset();
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    release_reset();

    // Arm with baseline 100, then a delta of 3
    cyc("idle2arm", 1, 0, 0, 48'd0, 0);
    cyc("arm",      1, 0, 1, 48'd100, 0);
    chk("armed_after_baseline", 64'(bus.armed), 64'd1);
    t_strobe = m_ts;
    cyc("strobe103", 1, 0, 1, 48'd103, 0);
    chk("latency_n1_valid", 64'(bus.dataValid), 64'd0);
    cyc("wait", 1, 0, 0, 48'd103, 0);
    chk("latency_n2_valid", 64'(bus.dataValid), 64'd1);
    chk("first_entry", bus.dataOut, {t_strobe, 16'd3});
    cyc("pop", 1, 0, 0, 48'd103, 1);

    // Modulo-2^48 wrap and saturation
    cyc("to_fffe",  1, 0, 1, 48'hFFFF_FFFF_FFFE, 0);
    cyc("wrap",     1, 0, 1, 48'd1, 0);
    cyc("to_zero",  1, 0, 1, 48'd0, 0);
    cyc("sat",      1, 0, 1, 48'd70000, 0);
    cyc("settle",   1, 0, 0, 48'd70000, 1);
    chk("wrap_delta", bus.dataOut[15:0], 16'd3);
    cyc("drain", 1, 0, 0, 48'd70000, 1);
    cyc("drain", 1, 0, 0, 48'd70000, 1);
    chk("sat_delta", bus.dataOut[15:0], 16'hFFFF);
    cyc("drain", 1, 0, 0, 48'd70000, 1);

    // Equal counts log nothing; ack on empty is harmless
    cyc("equal",  1, 0, 1, 48'd70000, 0);
    cyc("equal",  1, 0, 1, 48'd70000, 1);
    cyc("ackmt",  1, 0, 0, 48'd70000, 1);
    chk("empty_level", 64'(bus.fifoLevel), 64'd0);

    // Fill 16 + 3 dropped, then push with simultaneous pop
    cnt = 48'd70000;
    for (int i = 0; i < 19; i++) begin
      cnt = cnt + 48'd1;
      cyc("fill", 1, 0, 1, cnt, 0);
    end
    cyc("fill_end", 1, 0, 0, cnt, 0);
    chk("full_level", 64'(bus.fifoLevel), 64'd16);
    chk("full_drop",  64'(bus.dropCount), 64'd3);
    chk("full_ovf",   64'(bus.overflow),  64'd1);
    cnt = cnt + 48'd2;
    cyc("push_full", 1, 0, 1, cnt, 0);
    cyc("push_pop",  1, 0, 0, cnt, 1);
    chk("pushpop_level", 64'(bus.fifoLevel), 64'd16);
    chk("pushpop_drop",  64'(bus.dropCount), 64'd3);

    // Drain to 5, then clear with a push pending
    for (int i = 0; i < 11; i++) cyc("drain5", 1, 0, 0, cnt, 1);
    chk("level5", 64'(bus.fifoLevel), 64'd5);
    cnt = cnt + 48'd4;
    cyc("pend",  1, 0, 1, cnt, 0);
    cyc("clear", 1, 1, 1, cnt + 48'd9, 1);
    chk("clr_level", 64'(bus.fifoLevel), 64'd0);
    chk("clr_ovf",   64'(bus.overflow),  64'd0);
    chk("clr_armed", 64'(bus.armed),     64'd0);
    cyc("rearm",   1, 0, 0, cnt, 0);
    cyc("rebase",  1, 0, 1, cnt, 0);
    cyc("restrb",  1, 0, 1, cnt + 48'd7, 0);
    cyc("reread",  1, 0, 0, cnt, 0);
    chk("clr_ts", bus.dataOut, {48'd2, 16'd7});
    cnt = cnt + 48'd7;

    random_phase(300, 50);
    random_phase(200, 8);

    // Reset mid-operation with 7 entries stored
    cyc("pre_clr", 1, 1, 0, cnt, 0);
    cyc("arm7",    1, 0, 0, cnt, 0);
    cyc("base7",   1, 0, 1, cnt, 0);
    for (int i = 0; i < 7; i++) begin
      cnt = cnt + 48'd1;
      cyc("push7", 1, 0, 1, cnt, 0);
    end
    cnt = cnt + 48'd1;
    cyc("inflight", 1, 0, 1, cnt, 0);
    chk("level7", 64'(bus.fifoLevel), 64'd7);
    rstn = 1'b0;
    #1;
    check_reset_values("midreset");
    model_reset();
    bus.enable = 0; bus.sampleStrobe = 0; bus.rdAck = 0;
    @(posedge clk);
    release_reset();
    check_all("post_reset");

    random_phase(200, 40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/seu_error_event_logger.md
SEU_ERROR_EVENT_LOGGER -- requirements
Module: seu_error_event_logger

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning number of event entries (power of two, 4..64).
REQ-002 SHALL have parameter TS_WIDTH, default 48, meaning timestamp counter width.
REQ-003 SHALL have port clock  in  1  160 MHz bit clock (same clock that drives the PRBS7 data generator/checker).
REQ-004 SHALL have port RSTn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  in  1  logging enable, level.
REQ-006 SHALL have port clear  in  1  synchronous flush of FIFO, timestamp, drop counter, overflow.
REQ-007 SHALL have port sampleStrobe  in  1  single-cycle pulse marking errCount stable.
REQ-008 SHALL have port errCount  in  48  cumulative raw bit-error count from the PRBS7 checker.
REQ-009 SHALL have port rdAck  in  1  pops head entry when dataValid is high.
REQ-010 SHALL have port dataValid  out  1  FIFO not empty.
REQ-011 SHALL have port dataOut  out  64  head entry {timestamp[47:0], delta[15:0]}, first-word-fall-through.
REQ-012 SHALL have port fifoLevel  out  clog2(FIFO_DEPTH)+1  entries stored.
REQ-013 SHALL have port overflow  out  1  sticky, at least one event dropped.
REQ-014 SHALL have port dropCount  out  16  dropped events, saturating.
REQ-015 SHALL have port armed  out  1  high in RUN state.

Function
REQ-016 SHALL keep a free-running TS_WIDTH timestamp counter, +1 every clock, wrapping to 0 from all-ones.
REQ-017 SHALL implement states IDLE, ARM, RUN.
REQ-018 IDLE->ARM when enable=1; ARM->RUN on first sampleStrobe, capturing errCount as baseline with no event logged; RUN->IDLE when enable=0; ARM->IDLE when enable=0.
REQ-019 In RUN, on sampleStrobe: delta = errCount - baseline modulo 2^48; baseline <= errCount.
REQ-020 Delta SHALL saturate to 16'hFFFF when exceeding 65535.
REQ-021 Nonzero delta SHALL push {timestamp at strobe cycle, saturated delta}; zero delta SHALL push nothing.
REQ-022 Latency: strobe in cycle N with nonzero delta -> entry written at the end of cycle N+1, dataValid high in cycle N+2 if FIFO was empty.
REQ-023 sampleStrobe outside RUN SHALL be ignored except the ARM capture.
REQ-024 dataOut SHALL present head entry whenever dataValid=1; dataOut value is don't-care when empty.
REQ-025 rdAck with dataValid=0 SHALL be ignored (no underflow, level unchanged).
REQ-026 Simultaneous push and pop SHALL keep level constant, including when full (no drop).
REQ-027 Push when full without pop SHALL drop the entry, set overflow, increment dropCount, saturating at 16'hFFFF.
REQ-028 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifoLevel SHALL range 0..FIFO_DEPTH.
REQ-029 clear SHALL, in the next cycle: empty FIFO, zero timestamp, dropCount, overflow, discard any pending push; state->IDLE (re-arms via ARM if enable=1).
REQ-030 clear SHALL take priority over push, pop and strobe in the same cycle.
REQ-031 Leaving RUN SHALL NOT flush FIFO; stored entries remain readable.

Reset
REQ-032 RSTn=0 SHALL asynchronously force: state IDLE, timestamp 0, baseline 0, FIFO empty, dataValid 0, fifoLevel 0, overflow 0, dropCount 0, armed 0, dataOut 0.
REQ-033 Reset deassertion SHALL be synchronised internally; first state change earliest on second rising edge after RSTn rises.
REQ-034 Reset asserted mid-operation SHALL discard all entries and any in-flight push.

Verification
REQ-035 enable=1, strobe errCount=100 (arm), strobe errCount=103 at ts=T -> one entry {T,3}, dataValid two cycles after strobe, armed=1.
REQ-036 In RUN, baseline=48'hFFFF_FFFF_FFFE, strobe errCount=1 -> delta=3; baseline 0, errCount=70000 -> delta=16'hFFFF.
REQ-037 Fill 16 entries, push 3 more without rdAck -> level 16, overflow=1, dropCount=3; then push with rdAck same cycle -> level 16, dropCount stays 3.
REQ-038 Equal consecutive errCount strobes -> no entry; rdAck on empty -> level stays 0.
REQ-039 clear with FIFO at 5 and push pending -> next cycle level 0, overflow 0, timestamp 0, state IDLE then ARM.
REQ-040 RSTn low for one cycle with 7 entries -> dataValid 0 immediately, all outputs at REQ-032 values.
